// File: rtl/mesh_sort_ctrl.sv
// Shearsort sequencer for an SQRT_N x SQRT_N compare-exchange mesh: start/done handshake,
// one load cycle, then alternating row/column odd-even transposition phases.
// Optional build macro MESH_SORT_CTRL_STALL_EN adds a stall input that freezes the SORT sequence.
module mesh_sort_ctrl #(
  parameter int SQRT_N     = 8,
  parameter int LOG_SQRT_N = 3,
  parameter int PHASE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef MESH_SORT_CTRL_STALL_EN
  input  logic                  stall,
`endif
  output logic                  load_en,
  output logic                  cmp_en,
  output logic                  cmp_odd,
  output logic                  cmp_axis,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic [LOG_SQRT_N-1:0] step_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_PHASES = 2 * LOG_SQRT_N + 1;
  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [LOG_SQRT_N-1:0] LAST_STEP  = LOG_SQRT_N'(SQRT_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    load_en_nxt;
  logic                    cmp_en_nxt;
  logic                    cmp_odd_nxt;
  logic                    cmp_axis_nxt;
  logic [PHASE_W-1:0]      phase_nxt;
  logic [LOG_SQRT_N-1:0]   step_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic                    stall_req;
  logic                    last_step;

`ifdef MESH_SORT_CTRL_STALL_EN
  assign stall_req = stall;
`else
  assign stall_req = 1'b0;
`endif

  assign last_step = (phase_idx == LAST_PHASE) && (step_idx == LAST_STEP);

  // Next-state and next-output decode; every output is then registered below.
  always_comb begin
    state_nxt    = state;
    load_en_nxt  = 1'b0;
    cmp_en_nxt   = 1'b0;
    phase_nxt    = '0;
    step_nxt     = '0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = LOAD;
          load_en_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = SORT;
          cmp_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end
      end
      SORT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (stall_req) begin
          // The displayed step already executed; hold it visible with cmp_en low
          // and advance past it once the stall drops.
          phase_nxt = phase_idx;
          step_nxt  = step_idx;
          busy_nxt  = 1'b1;
        end else if (last_step) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          cmp_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
          if (step_idx == LAST_STEP) begin
            step_nxt  = '0;
            phase_nxt = phase_idx + 1'b1;
          end else begin
            step_nxt  = step_idx + 1'b1;
            phase_nxt = phase_idx;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    cmp_odd_nxt  = step_nxt[0];
    cmp_axis_nxt = phase_nxt[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      load_en   <= 1'b0;
      cmp_en    <= 1'b0;
      cmp_odd   <= 1'b0;
      cmp_axis  <= 1'b0;
      phase_idx <= '0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_en   <= load_en_nxt;
      cmp_en    <= cmp_en_nxt;
      cmp_odd   <= cmp_odd_nxt;
      cmp_axis  <= cmp_axis_nxt;
      phase_idx <= phase_nxt;
      step_idx  <= step_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// Scoreboard bench for mesh_sort_ctrl at default parameters: a full expected run is
// queued when a start is accepted and popped one entry per cycle against the DUT outputs.
module tb_mesh_sort_ctrl;

  localparam int SQRT_N     = 8;
  localparam int LOG_SQRT_N = 3;
  localparam int PHASE_W    = 4;
  localparam int NUM_PHASES = 2 * LOG_SQRT_N + 1;

  typedef struct packed {
    logic                  load_en;
    logic                  cmp_en;
    logic                  cmp_odd;
    logic                  cmp_axis;
    logic [PHASE_W-1:0]    phase;
    logic [LOG_SQRT_N-1:0] step;
    logic                  busy;
    logic                  done;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  abort;
`ifdef MESH_SORT_CTRL_STALL_EN
  logic                  stall;
`endif
  logic                  load_en;
  logic                  cmp_en;
  logic                  cmp_odd;
  logic                  cmp_axis;
  logic [PHASE_W-1:0]    phase_idx;
  logic [LOG_SQRT_N-1:0] step_idx;
  logic                  busy;
  logic                  done;

  exp_t q[$];
  exp_t cur;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   load_cyc;
  int   done_cyc;
  int   n_cmp;

  mesh_sort_ctrl #(
    .SQRT_N    (SQRT_N),
    .LOG_SQRT_N(LOG_SQRT_N),
    .PHASE_W   (PHASE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
`ifdef MESH_SORT_CTRL_STALL_EN
    .stall    (stall),
`endif
    .load_en  (load_en),
    .cmp_en   (cmp_en),
    .cmp_odd  (cmp_odd),
    .cmp_axis (cmp_axis),
    .phase_idx(phase_idx),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, expv);
    end
  endtask

  function automatic int outs();
    return int'({load_en, cmp_en, cmp_odd, cmp_axis, phase_idx, step_idx, busy, done});
  endfunction

  // Expected trace of one complete, uninterrupted sort.
  task automatic push_run();
    exp_t e;
    e = '0; e.load_en = 1'b1; e.busy = 1'b1;
    q.push_back(e);
    for (int p = 0; p < NUM_PHASES; p++) begin
      for (int s = 0; s < SQRT_N; s++) begin
        e = '0;
        e.cmp_en   = 1'b1;
        e.cmp_odd  = s[0];
        e.cmp_axis = p[0];
        e.phase    = PHASE_W'(p);
        e.step     = LOG_SQRT_N'(s);
        e.busy     = 1'b1;
        q.push_back(e);
      end
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    if (q.size() > 0) cur = q.pop_front();
    else              cur = '0;
    chk("load_en",   int'(load_en),   int'(cur.load_en));
    chk("cmp_en",    int'(cmp_en),    int'(cur.cmp_en));
    chk("cmp_odd",   int'(cmp_odd),   int'(cur.cmp_odd));
    chk("cmp_axis",  int'(cmp_axis),  int'(cur.cmp_axis));
    chk("phase_idx", int'(phase_idx), int'(cur.phase));
    chk("step_idx",  int'(step_idx),  int'(cur.step));
    chk("busy",      int'(busy),      int'(cur.busy));
    chk("done",      int'(done),      int'(cur.done));
    if (load_en) load_cyc = cyc;
    if (done)    done_cyc = cyc;
    if (cmp_en)  n_cmp++;
  endtask

  // Apply inputs for the coming edge and advance the scoreboard accordingly.
  task automatic drive(input logic st, input logic ab, input logic sl);
    bit   idle;
    exp_t e;
    idle  = !cur.busy && !cur.done && (q.size() == 0);
    start = st;
    abort = ab;
`ifdef MESH_SORT_CTRL_STALL_EN
    stall = sl;
`endif
    if (ab && cur.busy) begin
      q.delete();
    end else if (sl && cur.busy && !cur.load_en) begin
      e = cur;
      e.cmp_en = 1'b0;
      q.push_front(e);
    end else if (st && idle) begin
      push_run();
    end
  endtask

  task automatic run_full(input int stall_len);
    int acc;
    int n_st;
    bit stalled;
    bit seen_done;
    n_st = 0; stalled = 0; seen_done = 0; n_cmp = 0;
    sample();
    drive(1'b1, 1'b0, 1'b0);
    acc = cyc;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      sample();
      if (cur.done) seen_done = 1;
      if (!stalled && stall_len > 0 && cmp_en && phase_idx == 2 && step_idx == 3) begin
        stalled = 1;
        n_st    = stall_len;
      end
      if (n_st > 0) begin
        drive(1'b0, 1'b0, 1'b1);
        n_st--;
      end else begin
        drive(1'b0, 1'b0, 1'b0);
      end
    end
    chk("run_done_seen", int'(seen_done), 1);
    chk("load_latency",  load_cyc, acc + 1);
    chk("done_latency",  done_cyc, acc + 58 + stall_len);
    chk("cmp_count",     n_cmp, 56);
  endtask

  initial begin
    int l1;
    int l2;
    int d0;
    bit found;
    n_chk = 0; n_fail = 0; cyc = 0; load_cyc = -1; done_cyc = -1; n_cmp = 0;
    cur = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef MESH_SORT_CTRL_STALL_EN
    stall = 1'b0;
`endif
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    start = 1'b0;
    rst   = 1'b0;
    sample(); drive(1'b0, 1'b0, 1'b0);
    sample(); drive(1'b0, 1'b1, 1'b0);
    sample(); drive(1'b0, 1'b0, 1'b0);

    run_full(0);

    // start and abort together while idle: the start is taken.
    sample(); drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 62; i++) begin sample(); drive(1'b0, 1'b0, 1'b0); end

    // start held high: back-to-back runs, start ignored while busy or in DONE.
    l1 = -1; l2 = -1;
    for (int i = 0; i < 130; i++) begin
      sample();
      if (load_en) begin
        if (l1 < 0) l1 = cyc;
        else if (l2 < 0) l2 = cyc;
      end
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("b2b_load_gap", l2 - l1, 59);
    for (int i = 0; i < 70; i++) begin sample(); drive(1'b0, 1'b0, 1'b0); end

    // abort at phase 3, step 4.
    sample(); drive(1'b1, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      sample();
      if (cmp_en && phase_idx == 3 && step_idx == 4) begin
        found = 1;
        drive(1'b0, 1'b1, 1'b0);
      end else begin
        drive(1'b0, 1'b0, 1'b0);
      end
    end
    chk("abort_point_found", int'(found), 1);
    d0 = done_cyc;
    sample();
    chk("abort_outputs", outs(), 0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin sample(); drive(1'b0, 1'b0, 1'b0); end
    chk("abort_no_done", done_cyc, d0);
    run_full(0);

    // asynchronous reset in the middle of SORT.
    sample(); drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin sample(); drive(1'b0, 1'b0, 1'b0); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    q.delete();
    cur = '0;
    sample(); drive(1'b0, 1'b0, 1'b0);
    sample();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    run_full(0);

`ifdef MESH_SORT_CTRL_STALL_EN
    run_full(5);
`endif

    for (int i = 0; i < 3; i++) begin sample(); drive(1'b0, 1'b0, 1'b0); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
